// File: rtl/reset_pkg.sv
// Shared types for the core reset sequencer: FSM states, reset-cause
// bit positions and the cause vector type.
package reset_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_e;

    localparam int CAUSE_POR = 0;
    localparam int CAUSE_SW  = 1;
    localparam int CAUSE_WDT = 2;
    localparam int CAUSE_DBG = 3;

    typedef logic [3:0] cause_t;

    localparam cause_t CAUSE_RESET_VAL = cause_t'(4'b0001);

    // Packs individual cause flags into their fixed bit positions.
    function automatic cause_t cause_bits(input logic por, input logic sw,
                                          input logic wdt, input logic dbg);
        cause_t c;
        c            = '0;
        c[CAUSE_POR] = por;
        c[CAUSE_SW]  = sw;
        c[CAUSE_WDT] = wdt;
        c[CAUSE_DBG] = dbg;
        return c;
    endfunction

endpackage

// File: rtl/wdt_counter.sv
// Watchdog down-counter: reloads on load/kick, counts down while enabled,
// and flags expiry while it sits at zero with the enable high.
module wdt_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             enable_i,
    input  logic             kick_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i || kick_i) begin
            cnt_d = load_val_i;
        end else if (enable_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The enable is only high in RUN, and leaving RUN drops it, so this is one cycle wide.
    assign expire_o = enable_i && (cnt_q == '0);

endmodule

// File: rtl/reset_ctrl.sv
// Core reset sequencer: stretches every reset to a minimum hold time,
// releases stage resets in a staggered order and records the reset cause.
module reset_ctrl
    import reset_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 4,
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned WDT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sw_rst_req,
    input  logic                  dbg_rst_req,
    input  logic                  wdt_en,
    input  logic                  wdt_kick,
    input  logic [WDT_WIDTH-1:0]  wdt_load,
    input  logic                  cause_clr,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  rst_done,
    output logic [3:0]            rst_cause
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES);
    localparam int unsigned GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);

    state_e                state_q, state_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
    logic                  rst_done_q, rst_done_d;
    cause_t                cause_q, cause_d;

    logic                  stage_step;
    logic [NUM_STAGES-1:0] rst_out_shift;
    logic                  req_sw, req_dbg, req_wdt, req_any;
    logic                  wdt_load_strobe;
    logic                  wdt_run_en;
    logic                  wdt_run_kick;

    // Zeros shift in from the bottom, so stage 0 is always released first.
    assign rst_out_shift = rst_out_q << 1;

    // Requests only count once the hold phase is over; in HOLD, debug merely stretches it.
    assign req_sw  = sw_rst_req && (state_q != HOLD);
    assign req_dbg = dbg_rst_req && (state_q != HOLD);
    assign req_any = req_sw || req_dbg || req_wdt;

    assign wdt_run_en      = wdt_en && (state_q == RUN);
    assign wdt_run_kick    = wdt_kick && (state_q == RUN);
    assign wdt_load_strobe = (state_q != RUN) && (state_d == RUN);

    wdt_counter #(
        .WIDTH(WDT_WIDTH)
    ) u_wdt (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (wdt_load_strobe),
        .enable_i  (wdt_run_en),
        .kick_i    (wdt_run_kick),
        .load_val_i(wdt_load),
        .expire_o  (req_wdt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HOLD;
            hold_q     <= '0;
            gap_q      <= '0;
            rst_out_q  <= '1;
            rst_done_q <= 1'b0;
            cause_q    <= CAUSE_RESET_VAL;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            gap_q      <= gap_d;
            rst_out_q  <= rst_out_d;
            rst_done_q <= rst_done_d;
            cause_q    <= cause_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        gap_d      = gap_q;
        stage_step = 1'b0;
        if (req_any) begin
            state_d = HOLD;
            hold_d  = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (dbg_rst_req) begin
                        hold_d = '0;
                    end else if (hold_q == HOLD_LAST) begin
                        hold_d     = '0;
                        gap_d      = '0;
                        stage_step = 1'b1;
                        state_d    = (rst_out_shift == '0) ? RUN : RELEASE;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
                RELEASE: begin
                    if (gap_q == GAP_LAST) begin
                        gap_d      = '0;
                        stage_step = 1'b1;
                        state_d    = (rst_out_shift == '0) ? RUN : RELEASE;
                    end else begin
                        gap_d = gap_q + GW'(1);
                    end
                end
                RUN: begin
                    state_d = RUN;
                end
                default: begin
                    state_d = HOLD;
                    hold_d  = '0;
                    gap_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        rst_out_d = rst_out_q;
        if (req_any) begin
            rst_out_d = '1;
        end else if (stage_step) begin
            rst_out_d = rst_out_shift;
        end
        // Outputs are already all zero for the whole of RUN, so done lags the last release by one edge.
        rst_done_d = (state_q == RUN) && !req_any;
        cause_d    = (cause_clr ? cause_t'('0) : cause_q)
                   | cause_bits(1'b0, req_sw, req_wdt, req_dbg);
    end

    assign rst_out   = rst_out_q;
    assign rst_done  = rst_done_q;
    assign rst_cause = cause_q;

endmodule
